// File: rtl/inst_queue.sv
// Fetch-to-decode instruction queue: circular FIFO of {pc, inst} entries with a
// registered pop output, single-cycle flush and asynchronous active-low reset.
module inst_queue #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 64,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enqueue,
    input  logic [DATA_W-1:0] enqueue_wdata,
    output logic              is_full,
    input  logic              dequeue,
    output logic [DATA_W-1:0] dequeue_rdata,
    output logic              is_empty,
    input  logic              flush,
    output logic [PTR_W:0]    count
);

    localparam logic [PTR_W:0] PTR_ONE = (PTR_W+1)'(1);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W:0]    wr_ptr;
    logic [PTR_W:0]    rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    // Status comes from the pointers alone; the MSB is the wrap bit that
    // separates full from empty when the index bits match.
    assign is_empty = (wr_ptr == rd_ptr);
    assign is_full  = (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]) &&
                      (wr_ptr[PTR_W] != rd_ptr[PTR_W]);
    assign count    = wr_ptr - rd_ptr;

    assign push_ok = enqueue && !is_full && !flush;
    assign pop_ok  = dequeue && !is_empty && !flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            dequeue_rdata <= '0;
        end else if (flush) begin
            // dequeue_rdata is deliberately kept; decode drops its own copy.
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_ok) begin
                dequeue_rdata <= mem[rd_ptr[PTR_W-1:0]];
                rd_ptr        <= rd_ptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[PTR_W-1:0]] <= enqueue_wdata;
        end
    end

    a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst)
        !(push_ok && is_full));
    a_no_pop_when_empty: assert property (@(posedge clk) disable iff (!rst)
        !(pop_ok && is_empty));
    a_count_in_range: assert property (@(posedge clk) disable iff (!rst)
        count <= DEPTH_C);

endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue: fill/drain, wrap under steady push+pop,
// empty no-bypass, flush priority and asynchronous reset mid-stream.
module tb_inst_queue;

    localparam int DEPTH  = 16;
    localparam int DATA_W = 64;
    localparam int PTR_W  = $clog2(DEPTH);

    logic              clk;
    logic              rst;
    logic              enqueue;
    logic [DATA_W-1:0] enqueue_wdata;
    logic              is_full;
    logic              dequeue;
    logic [DATA_W-1:0] dequeue_rdata;
    logic              is_empty;
    logic              flush;
    logic [PTR_W:0]    count;

    int tests  = 0;
    int failed = 0;

    inst_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .enqueue       (enqueue),
        .enqueue_wdata (enqueue_wdata),
        .is_full       (is_full),
        .dequeue       (dequeue),
        .dequeue_rdata (dequeue_rdata),
        .is_empty      (is_empty),
        .flush         (flush),
        .count         (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] fill_val(input int i);
        return {32'h1000 + 32'(4 * i), 32'h13 + 32'(i)};
    endfunction

    function automatic logic [63:0] wrap_val(input int j);
        return {32'h3000 + 32'(4 * j), 32'h100 + 32'(j)};
    endfunction

    function automatic logic [63:0] flush_val(input int k);
        return {32'h4000 + 32'(4 * k), 32'h200 + 32'(k)};
    endfunction

    initial begin
        rst = 1'b0;
        enqueue = 1'b0;
        enqueue_wdata = '0;
        dequeue = 1'b0;
        flush = 1'b0;
        step();
        step();
        check("reset_empty", 64'(is_empty), 64'd1);
        check("reset_full", 64'(is_full), 64'd0);
        check("reset_count", 64'(count), 64'd0);
        check("reset_rdata", dequeue_rdata, 64'd0);
        rst = 1'b1;
        step();

        // fill 16 entries
        for (int i = 0; i < 16; i++) begin
            enqueue = 1'b1;
            enqueue_wdata = fill_val(i);
            step();
            check("fill_count", 64'(count), 64'(i + 1));
        end
        check("fill_full", 64'(is_full), 64'd1);
        enqueue_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
        step();
        check("overflow_count", 64'(count), 64'd16);
        check("overflow_full", 64'(is_full), 64'd1);
        enqueue = 1'b0;

        // drain; entry 0 must be untouched by the dropped 17th push
        dequeue = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step();
            check("drain_data", dequeue_rdata, fill_val(i));
        end
        check("drain_empty", 64'(is_empty), 64'd1);
        step();
        check("underflow_rdata", dequeue_rdata, {32'h103C, 32'h22});
        check("underflow_count", 64'(count), 64'd0);
        dequeue = 1'b0;

        // steady push+pop at count 5 across the pointer wrap
        enqueue = 1'b1;
        for (int j = 0; j < 5; j++) begin
            enqueue_wdata = wrap_val(j);
            step();
        end
        check("wrap_pre_count", 64'(count), 64'd5);
        dequeue = 1'b1;
        for (int j = 5; j < 25; j++) begin
            enqueue_wdata = wrap_val(j);
            step();
            check("wrap_data", dequeue_rdata, wrap_val(j - 5));
            check("wrap_count", 64'(count), 64'd5);
        end
        enqueue = 1'b0;
        for (int j = 20; j < 25; j++) begin
            step();
            check("wrap_tail", dequeue_rdata, wrap_val(j));
        end
        check("wrap_empty", 64'(is_empty), 64'd1);
        dequeue = 1'b0;

        // empty: simultaneous push and pop, no bypass
        enqueue = 1'b1;
        dequeue = 1'b1;
        enqueue_wdata = {32'h2000, 32'hDEADBEEF};
        step();
        check("nobypass_rdata", dequeue_rdata, wrap_val(24));
        check("nobypass_count", 64'(count), 64'd1);
        enqueue = 1'b0;
        step();
        check("nobypass_pop", dequeue_rdata, {32'h2000, 32'hDEADBEEF});
        check("nobypass_empty", 64'(is_empty), 64'd1);
        dequeue = 1'b0;

        // flush wins over enqueue and dequeue
        enqueue = 1'b1;
        for (int k = 0; k < 7; k++) begin
            enqueue_wdata = flush_val(k);
            step();
        end
        check("flush_pre_count", 64'(count), 64'd7);
        flush = 1'b1;
        dequeue = 1'b1;
        enqueue_wdata = 64'hAAAA_AAAA_5555_5555;
        step();
        check("flush_count", 64'(count), 64'd0);
        check("flush_empty", 64'(is_empty), 64'd1);
        check("flush_rdata", dequeue_rdata, {32'h2000, 32'hDEADBEEF});
        flush = 1'b0;
        dequeue = 1'b0;
        enqueue_wdata = {32'h5000, 32'h55};
        step();
        check("postflush_count", 64'(count), 64'd1);
        enqueue = 1'b0;
        dequeue = 1'b1;
        step();
        check("postflush_pop", dequeue_rdata, {32'h5000, 32'h55});
        dequeue = 1'b0;

        // asynchronous reset between edges at count 9
        enqueue = 1'b1;
        for (int k = 0; k < 9; k++) begin
            enqueue_wdata = flush_val(k);
            step();
        end
        enqueue = 1'b0;
        check("prereset_count", 64'(count), 64'd9);
        #3;
        rst = 1'b0;
        #1;
        check("async_count", 64'(count), 64'd0);
        check("async_empty", 64'(is_empty), 64'd1);
        check("async_rdata", dequeue_rdata, 64'd0);
        #1;
        rst = 1'b1;
        step();
        check("resume_count", 64'(count), 64'd0);
        enqueue = 1'b1;
        enqueue_wdata = {32'h6000, 32'h66};
        step();
        check("resume_push", 64'(count), 64'd1);
        enqueue = 1'b0;
        dequeue = 1'b1;
        step();
        check("resume_pop", dequeue_rdata, {32'h6000, 32'h66});
        check("resume_empty", 64'(is_empty), 64'd1);
        dequeue = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
